// File: rtl/seven_seg_capture.sv
// Recovers the digits shown on a multiplexed, active-low seven-segment display.
// Optional macro SEVEN_SEG_CAPTURE_ERR_EN adds per-digit flags for unrecognised patterns.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic [3:0]  digit_err
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIGIT_N = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t               state, state_n;
  logic [DIGIT_N-1:0]   an_q, an_p;
  logic [7:0]           seg_q, seg_p;
  logic [CNT_W-1:0]     cnt, cnt_next_c;
  logic                 legal_c, changed_c, sample_c, publish_c;
  logic [1:0]           idx_c;
  logic [3:0]           dec_nib_c;
  logic [15:0]          sh_val, nxt_val_c;
  logic [DIGIT_N-1:0]   sh_dp, nxt_dp_c, mask, nxt_mask_c;

  // Input registers plus a one-cycle-older copy used to detect changes
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an_q  <= 4'hF;
      seg_q <= 8'hFF;
      an_p  <= 4'hF;
      seg_p <= 8'hFF;
    end else begin
      an_q  <= AN;
      seg_q <= SEGMENT;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  always_comb begin
    legal_c = 1'b1;
    idx_c   = 2'd0;
    case (an_q)
      4'b1110: idx_c = 2'd0;
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: legal_c = 1'b0;
    endcase
  end

  assign changed_c = {an_q, seg_q} != {an_p, seg_p};

  // Stability counter: 1 on the first edge that sees a new value, saturating
  always_comb begin
    cnt_next_c = '0;
    if (legal_c) begin
      if (changed_c)                cnt_next_c = CNT_W'(1);
      else if (cnt == {CNT_W{1'b1}}) cnt_next_c = cnt;
      else                          cnt_next_c = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt <= '0;
    else     cnt <= cnt_next_c;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!legal_c)                          state_n = IDLE;
    else if (sample_c)                     state_n = HOLD;
    else if (changed_c || state == IDLE)   state_n = SETTLE;
  end

  // HOLD only samples again once the registered inputs move
  always_comb begin
    sample_c = 1'b0;
    if (legal_c && (state != HOLD || changed_c) && cnt_next_c == CNT_W'(STABLE_CYCLES))
      sample_c = 1'b1;
  end

  always_comb begin
    dec_nib_c = 4'h0;
    case (seg_q[6:0])
      7'b0000001: dec_nib_c = 4'h0;
      7'b1001111: dec_nib_c = 4'h1;
      7'b0010010: dec_nib_c = 4'h2;
      7'b0000110: dec_nib_c = 4'h3;
      7'b1001100: dec_nib_c = 4'h4;
      7'b0100100: dec_nib_c = 4'h5;
      7'b0100000: dec_nib_c = 4'h6;
      7'b0001111: dec_nib_c = 4'h7;
      7'b0000000: dec_nib_c = 4'h8;
      7'b0000100: dec_nib_c = 4'h9;
      7'b0001000: dec_nib_c = 4'hA;
      7'b1100000: dec_nib_c = 4'hB;
      7'b0110001: dec_nib_c = 4'hC;
      7'b1000010: dec_nib_c = 4'hD;
      7'b0110000: dec_nib_c = 4'hE;
      7'b0111000: dec_nib_c = 4'hF;
      default:    dec_nib_c = 4'h0;
    endcase
  end

  always_comb begin
    nxt_val_c                   = sh_val;
    nxt_val_c[{idx_c, 2'b00} +: 4] = dec_nib_c;
    nxt_dp_c                    = sh_dp;
    nxt_dp_c[idx_c]             = ~seg_q[7];
    nxt_mask_c                  = mask | ~an_q;
    publish_c                   = sample_c && nxt_mask_c == 4'hF;
  end

  // Shadow frame; published and cleared on the edge that completes it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh_val <= '0;
      sh_dp  <= '0;
      mask   <= '0;
      value  <= '0;
      dp     <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= publish_c;
      if (sample_c) begin
        sh_val <= nxt_val_c;
        sh_dp  <= nxt_dp_c;
        mask   <= publish_c ? 4'h0 : nxt_mask_c;
      end
      if (publish_c) begin
        value <= nxt_val_c;
        dp    <= nxt_dp_c;
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  logic [DIGIT_N-1:0] sh_err, nxt_err_c;
  logic               dec_bad_c;

  // Only the "0" pattern legitimately decodes to nibble 0
  assign dec_bad_c = dec_nib_c == 4'h0 && seg_q[6:0] != 7'b0000001;

  always_comb begin
    nxt_err_c        = sh_err;
    nxt_err_c[idx_c] = dec_bad_c;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh_err    <= '0;
      digit_err <= '0;
    end else begin
      if (sample_c)  sh_err    <= nxt_err_c;
      if (publish_c) digit_err <= nxt_err_c;
    end
  end
`else
  assign digit_err = 4'h0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: frame table, directed corner cases,
// and randomized scanning against a run-length based reference model.
module tb_seven_seg_capture;

  localparam int unsigned STABLE = 4;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid;
  logic [3:0]  digit_err;

  seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .clr(clr), .AN(AN), .SEGMENT(SEGMENT),
    .value(value), .dp(dp), .valid(valid), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;

  logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: the registered input and how many edges it has persisted
  logic [11:0] m_reg;
  int          m_run;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_sdp, m_serr, m_mask;
  logic [15:0] e_val;
  logic [3:0]  e_dp, e_err;
  logic        e_valid;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg = {4'hF, 8'hFF};
    m_run = 0;
    m_mask = '0; m_sdp = '0; m_serr = '0;
    for (int i = 0; i < 4; i++) m_nib[i] = '0;
    e_val = '0; e_dp = '0; e_err = '0; e_valid = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] an, input logic [7:0] seg, input logic c);
    int k;
    logic hit;
    logic [3:0] nib;
    if (c) begin
      model_reset();
      return;
    end
    e_valid = 1'b0;
    if ($countones(~m_reg[11:8]) == 1 && m_run == STABLE) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!m_reg[8+i]) k = i;
      hit = 1'b0; nib = 4'h0;
      for (int i = 0; i < 16; i++)
        if (codes[i] == m_reg[6:0]) begin hit = 1'b1; nib = 4'(i); end
      m_nib[k]  = nib;
      m_sdp[k]  = ~m_reg[7];
      m_serr[k] = ~hit;
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        e_val   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        e_dp    = m_sdp;
        e_err   = ERR_ON ? m_serr : 4'h0;
        e_valid = 1'b1;
        m_mask  = '0;
      end
    end
    if ({an, seg} == m_reg) m_run++;
    else begin m_reg = {an, seg}; m_run = 1; end
  endtask

  // One clock: drive at negedge, update model on posedge, compare at next negedge
  task automatic cyc(input logic [3:0] an, input logic [7:0] seg, input logic c);
    AN = an; SEGMENT = seg; clr = c;
    @(posedge clk);
    model_edge(an, seg, c);
    @(negedge clk);
    chk("cyc value", value, e_val);
    chk("cyc dp", 16'(dp), 16'(e_dp));
    chk("cyc digit_err", 16'(digit_err), 16'(e_err));
    chk("cyc valid", 16'(valid), 16'(e_valid));
    vcount += int'(valid);
  endtask

  task automatic scan(input int k, input logic [7:0] seg, input int n);
    logic [3:0] an;
    an = 4'hF;
    an[k] = 1'b0;
    for (int i = 0; i < n; i++) cyc(an, seg, 1'b0);
  endtask

  typedef struct {
    logic [3:0][7:0] segs;
    logic [15:0]     exp_val;
    logic [3:0]      exp_dp;
    logic [3:0]      exp_err;
  } frame_t;

  frame_t frames [4];
  int     v0;

  initial begin
    frames[0] = '{segs: {8'b10000001, 8'b10100100, 8'b11001100, 8'b10000110},
                  exp_val: 16'h0543, exp_dp: 4'h0, exp_err: 4'h0};
    frames[1] = '{segs: {8'b01000010, 8'b10110001, 8'b11100000, 8'b00001000},
                  exp_val: 16'hDCBA, exp_dp: 4'b1001, exp_err: 4'h0};
    frames[2] = '{segs: {8'b10111000, 8'b01111111, 8'b10100000, 8'b10000000},
                  exp_val: 16'hF068, exp_dp: 4'b0100, exp_err: 4'b0100};
    frames[3] = '{segs: {8'b10000100, 8'b00010010, 8'b10001111, 8'b10110000},
                  exp_val: 16'h927E, exp_dp: 4'b0100, exp_err: 4'h0};

    clr = 1'b1; AN = 4'hF; SEGMENT = 8'hFF;
    model_reset();
    @(negedge clk);
    chk("reset value", value, 16'h0000);
    chk("reset dp", 16'(dp), 16'h0);
    chk("reset valid", 16'(valid), 16'h0);
    chk("reset digit_err", 16'(digit_err), 16'h0);
    cyc(4'hF, 8'hFF, 1'b1);

    // Full frames from the table, each digit held 8 clocks
    foreach (frames[r]) begin
      v0 = vcount;
      for (int k = 0; k < 4; k++) scan(k, frames[r].segs[k], 8);
      cyc(4'hF, 8'hFF, 1'b0);
      chk($sformatf("frame%0d value", r), value, frames[r].exp_val);
      chk($sformatf("frame%0d dp", r), 16'(dp), 16'(frames[r].exp_dp));
      chk($sformatf("frame%0d digit_err", r), 16'(digit_err),
          16'(ERR_ON ? frames[r].exp_err : 4'h0));
      chk($sformatf("frame%0d valid pulses", r), 16'(vcount - v0), 16'd1);
    end

    // Two-digit-enable pattern between digits samples nothing
    cyc(4'hF, 8'hFF, 1'b1);
    scan(0, 8'b11001111, 8);
    scan(1, 8'b10010010, 8);
    v0 = vcount;
    for (int i = 0; i < 20; i++) cyc(4'b1100, 8'b10000000, 1'b0);
    chk("illegal an valid pulses", 16'(vcount - v0), 16'd0);
    chk("illegal an value held", value, 16'h0000);
    scan(2, 8'b10000110, 8);
    scan(3, 8'b11001100, 8);
    chk("after illegal value", value, 16'h4321);
    chk("after illegal pulses", 16'(vcount - v0), 16'd1);

    // Segment change after 3 clocks: only the second value is sampled, on its 4th edge
    cyc(4'hF, 8'hFF, 1'b1);
    scan(1, 8'b11001111, 8);
    scan(2, 8'b10010010, 8);
    scan(3, 8'b10000110, 8);
    v0 = vcount;
    scan(0, 8'b10100100, 3);
    scan(0, 8'b10000100, 4);
    chk("late sample no early valid", 16'(vcount - v0), 16'd0);
    cyc(4'hF, 8'hFF, 1'b0);
    chk("late sample valid edge", 16'(valid), 16'd1);
    chk("late sample value", value, 16'h3219);
    cyc(4'hF, 8'hFF, 1'b0);
    chk("late sample pulse width", 16'(valid), 16'd0);

    // Reset mid-frame discards three captured digits
    scan(0, 8'b10000000, 8);
    scan(1, 8'b10000000, 8);
    scan(2, 8'b10000000, 8);
    cyc(4'hF, 8'hFF, 1'b1);
    cyc(4'hF, 8'hFF, 1'b1);
    chk("clr value zero", value, 16'h0000);
    v0 = vcount;
    scan(3, 8'b10001111, 8);
    scan(0, 8'b10001111, 8);
    scan(1, 8'b10001111, 8);
    chk("clr partial no valid", 16'(vcount - v0), 16'd0);
    scan(2, 8'b10001111, 8);
    chk("clr refill valid", 16'(vcount - v0), 16'd1);
    chk("clr refill value", value, 16'h7777);

    // Repeated digit overwrites its shadow entry
    cyc(4'hF, 8'hFF, 1'b1);
    scan(0, 8'b11001111, 8);
    scan(0, 8'b10001111, 8);
    scan(1, 8'b10000001, 8);
    scan(2, 8'b10000001, 8);
    scan(3, 8'b10000001, 8);
    chk("overwrite value", value, 16'h0007);

    // Randomized scanning with illegal enables, glitches and resets
    for (int it = 0; it < 400; it++) begin
      logic [3:0] an;
      logic [7:0] seg;
      int hold;
      if ($urandom_range(99) < 85) begin
        an = 4'hF;
        an[$urandom_range(3)] = 1'b0;
      end else an = 4'($urandom);
      if ($urandom_range(99) < 80) seg = {1'($urandom), codes[$urandom_range(15)]};
      else seg = 8'($urandom);
      hold = $urandom_range(7, 1);
      for (int h = 0; h < hold; h++) cyc(an, seg, 1'b0);
      if ($urandom_range(99) < 2) cyc(4'hF, 8'hFF, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
